fifo_sync_flags: RTL and testbench

FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

---
 rtl/fifo_sync_flags.sv | 107 ++++++++++
 tb/tb_fifo_sync_flags.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered read data, registered occupancy flags
// and sticky overflow/underflow error flags.
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv, r_full, r_empty, r_af, r_ae, r_ovf, r_udf;

    logic                  w_rd_acc, w_wr_acc;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;

    // A write at full is only accepted when a read frees a slot on the same edge.
    assign w_rd_acc = rd_en && !r_empty && !clr;
    assign w_wr_acc = wr_en && (!r_full || w_rd_acc) && !clr;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr)
            w_cnt_nxt = '0;
        else if (w_wr_acc && !w_rd_acc)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (w_rd_acc && !w_wr_acc)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == DEPTH_C);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= AF_C);
            r_ae    <= (w_cnt_nxt <= AE_C);
            r_dv    <= w_rd_acc;
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else begin
                if (w_wr_acc)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_dout   <= r_mem[r_rd_ptr];
                end
                if (wr_en && !w_wr_acc)
                    r_ovf <= 1'b1;
                if (rd_en && !w_rd_acc)
                    r_udf <= 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dv;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: a behavioural occupancy model plus a data scoreboard
// that is filled on accepted writes and drained on every dout_valid pulse.
module tb_fifo_sync_flags;
    localparam int DW = 9, AW = 3, DEPTH = 8, AF = 6, AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int           n_chk = 0, n_err = 0;
    logic [DW-1:0] sb[$];
    int           m_cnt = 0;
    logic         m_ovf = 0, m_udf = 0, m_rd = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(m_cnt >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_cnt <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock: drive, update the model from pre-edge state, check after the edge.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic c);
        logic m_wr;
        logic [DW-1:0] exp;
        wr_en = w; rd_en = r; din = d; clr = c;
        m_rd = r && !c && (m_cnt != 0);
        m_wr = w && !c && ((m_cnt != DEPTH) || m_rd);
        if (c) begin
            sb.delete(); m_cnt = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (w && !m_wr) m_ovf = 1;
            if (r && !m_rd) m_udf = 1;
            if (m_wr) sb.push_back(d);
            m_cnt = m_cnt + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
        end
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clr = 0;
        chk({tag, ".dv"}, 32'(dout_valid), 32'(m_rd));
        if (dout_valid) begin
            if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'(dout), 32'hDEAD);
            else begin
                exp = sb.pop_front();
                chk({tag, ".dout"}, 32'(dout), 32'(exp));
            end
        end
        chk_flags(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".dout"}, 32'(dout), 32'h0);
        chk({tag, ".dv"}, 32'(dout_valid), 32'h0);
        chk_flags(tag);
    endtask

    initial begin
        sb.delete();
        #12;
        chk_reset_vals("rst");
        rst = 1'b1;
        @(posedge clk); #1;

        // fill/drain with overflow attempt at full
        for (int i = 1; i <= 8; i++) step("fill", 1, 0, DW'(i), 0);
        step("ovf", 1, 0, 9'h1FF, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 1, '0, 0);
        step("clr1", 0, 0, '0, 1);

        // write while empty with read: no bypass, underflow
        step("nobyp", 1, 1, 9'h0AA, 0);
        step("nobyp_rd", 0, 1, '0, 0);
        step("clr2", 0, 0, '0, 1);

        // simultaneous read/write at full, across wrap
        for (int i = 0; i < 8; i++) step("fill2", 1, 0, DW'(9'h010 + i), 0);
        step("rw_full", 1, 1, 9'h155, 0);
        for (int i = 0; i < 8; i++) step("drain2", 0, 1, '0, 0);
        chk("last_155", 32'(dout), 32'h155);

        // clr precedence with overflow set and count 5
        for (int i = 0; i < 8; i++) step("fill3", 1, 0, DW'(9'h020 + i), 0);
        step("ovf3", 1, 0, 9'h1FF, 0);
        for (int i = 0; i < 3; i++) step("rd3", 0, 1, '0, 0);
        step("clr_pri", 1, 1, 9'h0CC, 1);

        // random mix
        for (int i = 0; i < 300; i++)
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), ($urandom_range(0, 40) == 0));

        // async reset between edges with count 3
        step("clr4", 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, DW'(9'h040 + i), 0);
        step("pre_rst_rd", 1, 1, 9'h043, 0);
        #2 rst = 1'b0;
        #1;
        sb.delete(); m_cnt = 0; m_ovf = 0; m_udf = 0;
        chk_reset_vals("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        step("post_wr", 1, 0, 9'h077, 0);
        step("post_rd", 0, 1, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
